qk_core_seq: RTL and testbench

- Instruction sequencer for the attention core datapath.
- Produces the core's 17-bit instruction word each cycle for one full Q·K pass over 1..16 rows:
  - stream rows into qmem, then into kmem;
  - preload kmem rows into the MAC array;
  - execute with qmem rows;
  - drain the output FIFO into psum memory.
- Sits between the testbench/host row source and the core's `inst` input. The host only supplies `start`, a row count and a valid-qualified row stream.

---
 rtl/qk_core_seq.sv | 161 ++++++++++++++++
 tb/tb_qk_core_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/qk_core_seq.sv
`default_nettype none
// ==========================================================================
// qk_core_seq : instruction sequencer for one Q.K pass of the attention core
// rev 1.0
// ==========================================================================
module qk_core_seq #(
  parameter int ADDR_W    = 4,
  parameter int GAP       = 2,
  parameter int DRAIN_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] len_m1,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fifo_valid,
  output logic [16:0]       inst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        phase
);

  localparam int GAP_W = (GAP > 2) ? $clog2(GAP) : 1;
  localparam int TMO_W = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_Q  = 3'd1,
    ST_WR_K  = 3'd2,
    ST_LD_K  = 3'd3,
    ST_GAP   = 3'd4,
    ST_EXEC  = 3'd5,
    ST_DRAIN = 3'd6,
    ST_FIN   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              cnt_last;
  logic [ADDR_W-1:0] cnt_next;

  // The row counter always wraps to zero on the phase-exit row, never past it.
  assign cnt_last = (cnt_q == len_q);
  assign cnt_next = cnt_last ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    gap_d   = '0;
    tmo_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len_m1;
          cnt_d   = '0;
          state_d = ST_WR_Q;
        end
      end
      ST_WR_Q, ST_WR_K: begin
        if (in_valid) begin
          cnt_d = cnt_next;
          if (cnt_last) state_d = (state_q == ST_WR_Q) ? ST_WR_K : ST_LD_K;
        end
      end
      ST_LD_K: begin
        cnt_d = cnt_next;
        if (cnt_last) state_d = (GAP == 0) ? ST_EXEC : ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_W'(GAP - 1)) begin
          gap_d   = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_next;
        if (cnt_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_valid) begin
          cnt_d = cnt_next;
          if (cnt_last) state_d = ST_FIN;
        end else if (tmo_q == TMO_W'(DRAIN_MAX - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Only the write/drain qualifiers look at inputs; everything else is decoded from flops.
  always_comb begin
    inst = '0;
    case (state_q)
      ST_WR_Q: begin
        inst[15:12] = 4'(cnt_q);
        inst[4]     = in_valid;
      end
      ST_WR_K: begin
        inst[15:12] = 4'(cnt_q);
        inst[2]     = in_valid;
      end
      ST_LD_K: begin
        inst[15:12] = 4'(cnt_q);
        inst[6]     = 1'b1;
        inst[3]     = 1'b1;
      end
      ST_EXEC: begin
        inst[15:12] = 4'(cnt_q);
        inst[7]     = 1'b1;
        inst[5]     = 1'b1;
      end
      ST_DRAIN: begin
        inst[11:8] = 4'(cnt_q);
        inst[16]   = fifo_valid;
        inst[0]    = fifo_valid;
      end
      default: inst = '0;
    endcase
  end

  assign in_ready = in_valid && ((state_q == ST_WR_Q) || (state_q == ST_WR_K));
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);
  assign err      = err_q;
  assign phase    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_qk_core_seq.sv
`default_nettype none
// Bench for qk_core_seq: pass-level reference model feeding a per-cycle scoreboard.
module tb_qk_core_seq;

  localparam int ADDR_W    = 4;
  localparam int GAP       = 2;
  localparam int DRAIN_MAX = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] len_m1;
  logic              in_valid;
  logic              in_ready;
  logic              fifo_valid;
  logic [16:0]       inst;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        phase;

  qk_core_seq #(
    .ADDR_W    (ADDR_W),
    .GAP       (GAP),
    .DRAIN_MAX (DRAIN_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len_m1     (len_m1),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fifo_valid (fifo_valid),
    .inst       (inst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] inst;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  phase;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Monitor: every cycle with an expectation queued is compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = sb_q.pop_front();
      a = {inst, in_ready, busy, done, err, phase};
      n_vec++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL outputs @%0t: got inst=%h rdy=%b busy=%b done=%b err=%b phase=%0d, want inst=%h rdy=%b busy=%b done=%b err=%b phase=%0d",
                 $time, a.inst, a.rdy, a.busy, a.done, a.err, a.phase,
                 e.inst, e.rdy, e.busy, e.done, e.err, e.phase);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [ADDR_W-1:0] rl();
    return ADDR_W'($urandom_range(0, 15));
  endfunction

  task automatic step(input logic rs, input logic st, input logic [ADDR_W-1:0] ln,
                      input logic iv, input logic fv, input logic push,
                      input logic [16:0] ei, input logic er, input logic eb,
                      input logic ed, input logic ee, input logic [2:0] ep);
    reset      = rs;
    start      = st;
    len_m1     = ln;
    in_valid   = iv;
    fifo_valid = fv;
    if (push) sb_q.push_back({ei, er, eb, ed, ee, ep});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input logic st, input logic ee);
    step(1'b0, st, rl(), rb(), rb(), 1'b1, 17'h0, 1'b0, 1'b0, 1'b0, ee, 3'd0);
  endtask

  // vmode: 0 valid always, 1 random, 2 toggling from 0.  fmode: 0 fifo always, 1 random.
  // to_after >= 0: stop supplying fifo rows after that many drained rows.
  // abort_at >= 0: reset on that EXEC row.
  task automatic run_pass(input logic [ADDR_W-1:0] ln, input int vmode, input int fmode,
                          input int to_after, input int abort_at);
    int   a;
    int   k;
    int   stalls;
    logic v;
    logic f;
    step(1'b0, 1'b1, ln, rb(), rb(), 1'b1, 17'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int ph = 0; ph < 2; ph++) begin
      a = 0;
      k = 0;
      while (a <= int'(ln)) begin
        v = (vmode == 0) ? 1'b1 : (vmode == 2) ? k[0] : ($urandom_range(0, 3) != 0);
        step(1'b0, rb(), rl(), v, rb(), 1'b1,
             (17'(a) << 12) | (v ? ((ph == 0) ? 17'h10 : 17'h4) : 17'h0),
             v, 1'b1, 1'b0, 1'b0, (ph == 0) ? 3'd1 : 3'd2);
        if (v) a++;
        k++;
      end
    end
    for (a = 0; a <= int'(ln); a++)
      step(1'b0, rb(), rl(), rb(), rb(), 1'b1, (17'(a) << 12) | 17'h48,
           1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
    for (int g = 0; g < GAP; g++)
      step(1'b0, rb(), rl(), rb(), rb(), 1'b1, 17'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4);
    for (a = 0; a <= int'(ln); a++) begin
      step((a == abort_at), rb(), rl(), rb(), rb(), 1'b1, (17'(a) << 12) | 17'hA0,
           1'b0, 1'b1, 1'b0, 1'b0, 3'd5);
      if (a == abort_at) begin
        idle_chk(1'b0, 1'b0);
        idle_chk(1'b0, 1'b0);
        return;
      end
    end
    a = 0;
    stalls = 0;
    while (a <= int'(ln)) begin
      if (to_after >= 0 && a >= to_after) f = 1'b0;
      else if (fmode == 0)                 f = 1'b1;
      else if (stalls >= 40)               f = 1'b1;
      else                                 f = ($urandom_range(0, 2) != 0);
      step(1'b0, rb(), rl(), rb(), f, 1'b1,
           f ? ((17'(a) << 8) | 17'h10001) : (17'(a) << 8),
           1'b0, 1'b1, 1'b0, 1'b0, 3'd6);
      if (f) begin
        a++;
        stalls = 0;
      end else begin
        stalls++;
        if (stalls == DRAIN_MAX) begin
          idle_chk(1'b0, 1'b1);
          idle_chk(1'b0, 1'b0);
          return;
        end
      end
    end
    step(1'b0, rb(), rl(), rb(), rb(), 1'b1, 17'h0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7);
    idle_chk(1'b0, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    len_m1     = '0;
    in_valid   = 1'b0;
    fifo_valid = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 17'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b1, '0, 1'b1, 1'b1, 1'b0, 17'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 17'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    run_pass(4'd3,  0, 0, -1, -1);
    run_pass(4'd1,  2, 0, -1, -1);
    run_pass(4'd15, 0, 0, -1, -1);
    run_pass(4'd15, 1, 1, -1, -1);
    run_pass(4'd3,  0, 0,  0, -1);
    run_pass(4'd5,  1, 1,  2, -1);
    run_pass(4'd3,  1, 0, -1,  2);
    run_pass(4'd0,  0, 0, -1, -1);

    // Reset and start together in IDLE: reset must win.
    step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 17'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle_chk(1'b0, 1'b0);

    for (int p = 0; p < 25; p++) begin
      int to;
      int ab;
      logic [ADDR_W-1:0] ln;
      ln = rl();
      to = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 32'(ln))) : -1;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 32'(ln))) : -1;
      run_pass(ln, 1, int'($urandom_range(0, 1)), to, ab);
    end

    if (sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
